phase_ctrl: RTL and testbench
=============================

# phase_ctrl

Multi-cycle phase sequencer for the 16-bit processor core. It steps the datapath through five phases per instruction: P1 fetch, P2 decode/register read, P3 execute, P4 memory, P5 writeback. It stretches P1 and memory-phase P4 while memory is not ready, and handles run/stop/single-step control and the HLT instruction. Its phase outputs qualify every per-phase stage, including writeback-enable generation.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: level-sampled run request, honoured only in IDLE or HALT.
- `stop` in 1: request to stop after the current instruction completes.
- `step_mode` in 1: when 1, execute exactly one instruction per `start`.
- `mem_rdy` in 1: memory ready; a memory phase completes only in a cycle where this is 1.
- `instr` in 16: current instruction register, valid from P2 onward.
- `phase` out 3: binary phase index; 0 = no phase (IDLE/HALT), 1..5 = P1..P5.
- `phase_oh` out 5: one-hot phase, bit k-1 = Pk; all zero outside RUN.
- `ir_load` out 1: load instruction register; high in a P1 cycle where `mem_rdy` = 1.
- `pc_en` out 1: advance PC; high for the single P5 cycle.
- `running` out 1: state == RUN.
- `halted` out 1: state == HALT.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States:
  - IDLE: reset state.
  - RUN: carries a phase counter 1..5.
  - HALT.
- IDLE → RUN(P1) when `start` = 1.
- HALT → RUN(P1) when `start` = 1. Entering RUN from HALT does not clear `retired`.
- Phase advance in RUN, per cycle:
  - P1 advances to P2 only if `mem_rdy`; otherwise it holds.
  - P2 and P3 always advance.
  - P4 is a memory phase when `instr[15:14]` is 2'b00 (LD) or 2'b01 (ST). A memory P4 holds until `mem_rdy`; any other P4 advances unconditionally.
  - P5 always completes in one cycle.
- Leaving P5:
  - `retired` increments, wrapping modulo 2^CNT_W.
  - Next state is chosen by priority:
    1. HLT (`instr[15:14]` = 2'b11 and `instr[7:4]` = 4'b1111) → HALT.
    2. Else, `stop_pend` or `step_mode` → IDLE.
    3. Else → P1.
- `stop_pend` is a sticky flag:
  - Set when `stop` = 1 in any RUN cycle.
  - Cleared on entry to IDLE or HALT.
  - A `stop` in the P5 cycle itself takes effect at that P5.
- `start` while in RUN is ignored.
- `stop` while in IDLE or HALT is ignored and does not set `stop_pend`.
- Simultaneous HLT and stop at P5: go to HALT (HLT wins).

## Timing
- Outputs are registered state or pure decode of state, phase and `mem_rdy`. There is no other combinational path from inputs.
- Reset values: state = IDLE, `phase` = 0, `phase_oh` = 0, `ir_load` = 0, `pc_en` = 0, `running` = 0, `halted` = 0, `retired` = 0, `stop_pend` = 0.
- Reset asserted mid-instruction aborts immediately to IDLE. There is no partial retirement.
- Latency:
  - `start` sampled high at edge N puts P1 in the cycle after edge N.
  - With `mem_rdy` held at 1, an instruction takes exactly 5 cycles.
  - Each memory-wait cycle adds 1 cycle.
- `ir_load` and `pc_en` are single-cycle strobes per instruction.
- `retired` updates on the edge that ends P5.

## Structure
- Shared package `core_pkg` holds:
  - phase index constants `PH_NONE` = 0 and `PH_P1`..`PH_P5` = 1..5;
  - state enum IDLE/RUN/HALT;
  - opcode-field constants `OP_LD` = 2'b00, `OP_ST` = 2'b01, `OP_ALU` = 2'b11, `FN_HLT` = 4'b1111;
  - helper functions `is_mem(instr)` and `is_hlt(instr)`.
- One natural sub-module: `retire_counter`, a CNT_W-bit enable counter with asynchronous active-low reset.
- The FSM and phase counter stay in `phase_ctrl`.

## Test plan
- Reset, then `start` pulse with `mem_rdy` = 1 and ALU `instr` 16'hC000 → phase 1,2,3,4,5,1…; `pc_en` high on every 5th cycle; `retired` = 4 after 20 cycles.
- LD `instr` 16'h0000 with `mem_rdy` low for 3 cycles in P1 and 2 cycles in P4 → instruction takes 10 cycles; `ir_load` pulses once, in the P1 cycle where `mem_rdy` rises.
- HLT `instr` 16'hC0F0 → after P5, `halted` = 1 and `phase` = 0; `start` resumes at P1 with `retired` continuing from 1.
- `step_mode` = 1 with two `start` pulses → exactly two instructions run; IDLE between them; `retired` = 2.
- `stop` pulsed during P2 → current instruction completes and `retired` increments; IDLE follows P5. `stop` and HLT both present at P5 → HALT.
- `rst_n` asserted during P3 → all outputs return to reset values asynchronously; `retired` = 0; next `start` begins at P1.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared phase, state and opcode definitions for the 16-bit core.
package core_pkg;
    localparam logic [2:0] PH_NONE = 3'd0;
    localparam logic [2:0] PH_P1   = 3'd1;
    localparam logic [2:0] PH_P2   = 3'd2;
    localparam logic [2:0] PH_P3   = 3'd3;
    localparam logic [2:0] PH_P4   = 3'd4;
    localparam logic [2:0] PH_P5   = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b11;
    localparam logic [3:0] FN_HLT = 4'b1111;

    function automatic logic is_mem(input logic [15:0] instr);
        return instr[15:14] == OP_LD || instr[15:14] == OP_ST;
    endfunction

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:14] == OP_ALU && instr[7:4] == FN_HLT;
    endfunction
endpackage

// File: rtl/retire_counter.sv
// retire_counter: wrapping enable counter of completed instructions.
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (en) count <= count + 1'b1;
    end
endmodule

// File: rtl/phase_ctrl.sv
// phase_ctrl: five-phase instruction sequencer with memory stretching,
// run/stop/single-step control and HLT handling.
module phase_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step_mode,
    input  logic             mem_rdy,
    input  logic [15:0]      instr,
    output logic [2:0]       phase,
    output logic [4:0]       phase_oh,
    output logic             ir_load,
    output logic             pc_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    state_t     state, state_nx;
    logic [2:0] ph, ph_nx;
    logic       stop_pend, stop_pend_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ph        <= PH_NONE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            ph        <= ph_nx;
            stop_pend <= stop_pend_nx;
        end
    end

    // ph is held at PH_NONE whenever the FSM is outside RUN
    always_comb begin
        state_nx     = state;
        ph_nx        = ph;
        stop_pend_nx = 1'b0;
        case (state)
            RUN: begin
                stop_pend_nx = stop_pend | stop;
                case (ph)
                    PH_P1: ph_nx = mem_rdy ? PH_P2 : PH_P1;
                    PH_P4: ph_nx = (!is_mem(instr) || mem_rdy) ? PH_P5 : PH_P4;
                    PH_P5: begin
                        ph_nx = PH_P1;
                        if (is_hlt(instr) || stop_pend || stop || step_mode) begin
                            state_nx     = is_hlt(instr) ? HALT : IDLE;
                            ph_nx        = PH_NONE;
                            stop_pend_nx = 1'b0;
                        end
                    end
                    default: ph_nx = ph + 3'd1;
                endcase
            end
            IDLE, HALT: begin
                state_nx = start ? RUN : state;
                ph_nx    = start ? PH_P1 : PH_NONE;
            end
            default: begin
                state_nx = IDLE;
                ph_nx    = PH_NONE;
            end
        endcase
    end

    always_comb begin
        running  = state == RUN;
        halted   = state == HALT;
        phase    = running ? ph : PH_NONE;
        phase_oh = (running && ph != PH_NONE) ? 5'b1 << (ph - 3'd1) : 5'b0;
        ir_load  = running && ph == PH_P1 && mem_rdy;
        pc_en    = running && ph == PH_P5;
    end

    retire_counter #(.CNT_W(CNT_W)) u_retire (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pc_en),
        .count(retired)
    );
endmodule

// File: tb/tb_phase_ctrl.sv
// tb_phase_ctrl: vector-table and scoreboard bench for phase_ctrl.
module tb_phase_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        start = 0, stop = 0, step_mode = 0, mem_rdy = 0;
    logic [15:0] instr = 16'h0;
    logic [2:0]  phase;
    logic [4:0]  phase_oh;
    logic        ir_load, pc_en, running, halted;
    logic [15:0] retired;

    int errors = 0, checks = 0;

    localparam logic [15:0] ALU = 16'hC000, LD = 16'h0000, HLT = 16'hC0F0;

    typedef struct {
        logic        st, sp, sm, rdy;
        logic [15:0] ins;
        logic [2:0]  ph;
        logic        hlt;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    phase_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_mode(step_mode),
        .mem_rdy(mem_rdy), .instr(instr), .phase(phase), .phase_oh(phase_oh),
        .ir_load(ir_load), .pc_en(pc_en), .running(running), .halted(halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic st, sp, sm, rdy, input logic [15:0] ins,
                                input logic [2:0] ph, input logic hlt, input logic [15:0] ret);
        vec_t v;
        v.st = st; v.sp = sp; v.sm = sm; v.rdy = rdy; v.ins = ins;
        v.ph = ph; v.hlt = hlt; v.ret = ret;
        vecs.push_back(v);
    endfunction

    task automatic check_all(input string tag, input logic [2:0] ph, input logic rdy,
                             input logic hlt, input logic [15:0] ret);
        chk({tag, " phase"}, 32'(phase), 32'(ph));
        chk({tag, " phase_oh"}, 32'(phase_oh), ph == 0 ? 32'd0 : 32'd1 << (ph - 1));
        chk({tag, " ir_load"}, 32'(ir_load), 32'(ph == 1 && rdy));
        chk({tag, " pc_en"}, 32'(pc_en), 32'(ph == 5));
        chk({tag, " running"}, 32'(running), 32'(ph != 0));
        chk({tag, " halted"}, 32'(halted), 32'(hlt));
        chk({tag, " retired"}, 32'(retired), 32'(ret));
    endtask

    initial begin
        vec_t e;
        // ALU stream, stop in the final P5
        add(1,0,0,1,ALU,0,0,0);
        for (int i = 0; i < 20; i++) add(0, i == 19, 0, 1, ALU, 3'(i % 5 + 1), 0, 16'(i / 5));
        add(0,0,0,1,ALU,0,0,4);
        // LD with 3 P1 waits and 2 P4 waits, stop during P2
        add(1,0,0,0,LD,0,0,4);
        for (int i = 0; i < 3; i++) add(0,0,0,0,LD,1,0,4);
        add(0,0,0,1,LD,1,0,4);
        add(0,1,0,0,LD,2,0,4);
        add(0,0,0,0,LD,3,0,4);
        add(0,0,0,0,LD,4,0,4);
        add(0,0,0,0,LD,4,0,4);
        add(0,0,0,1,LD,4,0,4);
        add(0,0,0,0,LD,5,0,4);
        add(0,0,0,1,ALU,0,0,5);
        // HLT with non-memory P4 under mem_rdy low, stop and HLT together at P5
        add(1,0,0,1,HLT,0,0,5);
        add(0,0,0,1,HLT,1,0,5);
        add(0,0,0,1,HLT,2,0,5);
        add(0,0,0,1,HLT,3,0,5);
        add(0,0,0,0,HLT,4,0,5);
        add(0,1,0,1,HLT,5,0,5);
        add(0,0,0,1,HLT,0,1,6);
        add(0,1,0,1,HLT,0,1,6);
        add(1,0,0,1,ALU,0,1,6);
        for (int p = 1; p <= 5; p++) add(0,0,0,1,ALU,3'(p),0,6);
        for (int p = 1; p <= 5; p++) add(0,0,1,1,ALU,3'(p),0,7);
        add(0,0,1,1,ALU,0,0,8);
        // single-step: two starts, start ignored while running
        add(1,0,1,1,ALU,0,0,8);
        for (int p = 1; p <= 5; p++) add(p == 3,0,1,1,ALU,3'(p),0,8);
        add(0,0,1,1,ALU,0,0,9);
        add(0,0,1,1,ALU,0,0,9);
        add(1,0,1,1,ALU,0,0,9);
        for (int p = 1; p <= 5; p++) add(0,0,1,1,ALU,3'(p),0,9);
        add(0,0,1,1,ALU,0,0,10);

        #3;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            start = vecs[i].st; stop = vecs[i].sp; step_mode = vecs[i].sm;
            mem_rdy = vecs[i].rdy; instr = vecs[i].ins;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check_all($sformatf("v%0d", i), e.ph, e.rdy, e.hlt, e.ret);
        end

        // asynchronous reset in P3
        @(posedge clk); #1 start = 1; step_mode = 0; stop = 0; mem_rdy = 1; instr = ALU;
        @(posedge clk); #1 start = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("pre-reset phase", 32'(phase), 32'd3);
        rst_n = 0; #1;
        check_all("async reset", 0, 1, 0, 0);
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        check_all("post reset idle", 0, 1, 0, 0);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        check_all("restart P1", 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
